// File: rtl/mul_arb_pkg.sv
// Shared constants, tag type and helpers for the multiplier arbiter.
package mul_arb_pkg;

  localparam int OP_W    = 32;
  localparam int PROD_W  = 64;
  localparam int MAX_REQ = 8;

  // One stage of the tag pipe: marks a live operation and who issued it.
  typedef struct packed {
    logic       valid;
    logic [2:0] id;
  } tag_t;

  // Expand a requester index into a MAX_REQ-wide one-hot vector.
  function automatic logic [MAX_REQ-1:0] onehot(input logic [2:0] id);
    logic [MAX_REQ-1:0] oh;
    oh     = {MAX_REQ{1'b0}};
    oh[id] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mul_arbiter_rr.sv
// Round-robin arbiter: one-hot grant to the first active request at or
// after ptr, wrapping modulo N. Purely combinational; en=0 grants nothing.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt
);

  // Scan from ptr upward, wrapping once, and grant the first request seen.
  always_comb begin : scan_p
    logic [PW:0] pos;
    logic        found;
    gnt   = {N{1'b0}};
    found = 1'b0;
    pos   = {(PW+1){1'b0}};
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr} + (PW+1)'(k);
      if (pos >= (PW+1)'(N)) begin
        pos = pos - (PW+1)'(N);
      end else begin
        pos = pos;
      end
      if (en && !found && req[pos[PW-1:0]]) begin
        gnt[pos[PW-1:0]] = 1'b1;
        found            = 1'b1;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// Shares one fixed-latency 32x32->64 multiplier among N_REQ requesters.
// Round-robin grants, registered operands, and a {valid,id} tag pipe that
// steers each product back to its issuer LATENCY+1 edges after transfer.
// Optional build macro MUL_ARB_PERF_EN adds per-requester grant counters.
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int LATENCY = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       hold,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [OP_W*N_REQ-1:0]      req_a,
  input  logic [OP_W*N_REQ-1:0]      req_b,
  output logic [OP_W-1:0]            mul_a,
  output logic [OP_W-1:0]            mul_b,
  input  logic [PROD_W-1:0]          mul_r,
  output logic [N_REQ-1:0]           rsp_valid,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic [PROD_W-1:0]          rsp_r,
  output logic [3:0]                 inflight,
`ifdef MUL_ARB_PERF_EN
  output logic [16*N_REQ-1:0]        grant_cnt,
`endif
  output logic                       idle
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int DEPTH = LATENCY + 1;

  logic [N_REQ-1:0]  gnt_s;
  logic              en_s;
  logic              xfer_s;
  logic [2:0]        xfer_id_s;
  logic [OP_W-1:0]   op_a_s;
  logic [OP_W-1:0]   op_b_s;
  logic [ID_W-1:0]   ptr_nxt_s;
  tag_t              last_s;
  logic [N_REQ-1:0]  rsp_oh_s;
  logic [3:0]        inflight_nxt_s;

  logic [ID_W-1:0]   rr_ptr_r;
  logic [OP_W-1:0]   mul_a_r;
  logic [OP_W-1:0]   mul_b_r;
  tag_t              tag_r [DEPTH];
  logic [N_REQ-1:0]  rsp_valid_r;
  logic [ID_W-1:0]   rsp_id_r;
  logic [PROD_W-1:0] rsp_r_r;
  logic [3:0]        inflight_r;
  logic              idle_r;

  assign en_s = ~hold;

  rr_arbiter #(.N(N_REQ), .PW(ID_W)) u_rr (
    .req (req_valid),
    .ptr (rr_ptr_r),
    .en  (en_s),
    .gnt (gnt_s)
  );

  assign req_ready = gnt_s;

  // Decode the winning requester into an index and select its operands.
  always_comb begin
    xfer_s    = 1'b0;
    xfer_id_s = 3'd0;
    op_a_s    = {OP_W{1'b0}};
    op_b_s    = {OP_W{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_s[i] && req_valid[i]) begin
        xfer_s    = 1'b1;
        xfer_id_s = 3'(i);
        op_a_s    = req_a[i*OP_W +: OP_W];
        op_b_s    = req_b[i*OP_W +: OP_W];
      end else begin
        xfer_s = xfer_s;
      end
    end
  end

  // Pointer moves just past the requester that was served, else it holds.
  always_comb begin
    if (xfer_s) begin
      if (xfer_id_s == 3'(N_REQ - 1)) begin
        ptr_nxt_s = {ID_W{1'b0}};
      end else begin
        ptr_nxt_s = ID_W'(xfer_id_s + 3'd1);
      end
    end else begin
      ptr_nxt_s = rr_ptr_r;
    end
  end

  assign last_s   = tag_r[LATENCY];
  assign rsp_oh_s = N_REQ'(onehot(last_s.id));

  // Occupancy bookkeeping: +1 per transfer, -1 per response strobe.
  always_comb begin
    case ({xfer_s, last_s.valid})
      2'b10:   inflight_nxt_s = inflight_r + 4'd1;
      2'b01:   inflight_nxt_s = inflight_r - 4'd1;
      default: inflight_nxt_s = inflight_r;
    endcase
  end

  // Register operands toward the multiplier and advance the round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a_r  <= {OP_W{1'b0}};
      mul_b_r  <= {OP_W{1'b0}};
      rr_ptr_r <= {ID_W{1'b0}};
    end else if (xfer_s) begin
      mul_a_r  <= op_a_s;
      mul_b_r  <= op_b_s;
      rr_ptr_r <= ptr_nxt_s;
    end else begin
      mul_a_r  <= mul_a_r;
      mul_b_r  <= mul_b_r;
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // Tag pipe shifts every cycle without stalling, mirroring multiplier latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < DEPTH; j++) begin
        tag_r[j] <= tag_t'(4'b0000);
      end
    end else begin
      tag_r[0] <= '{valid: xfer_s, id: xfer_id_s};
      for (int j = 1; j < DEPTH; j++) begin
        tag_r[j] <= tag_r[j-1];
      end
    end
  end

  // Capture the product when the oldest tag is live; otherwise just drop the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_r <= {N_REQ{1'b0}};
      rsp_id_r    <= {ID_W{1'b0}};
      rsp_r_r     <= {PROD_W{1'b0}};
    end else if (last_s.valid) begin
      rsp_valid_r <= rsp_oh_s;
      rsp_id_r    <= ID_W'(last_s.id);
      rsp_r_r     <= mul_r;
    end else begin
      rsp_valid_r <= {N_REQ{1'b0}};
      rsp_id_r    <= rsp_id_r;
      rsp_r_r     <= rsp_r_r;
    end
  end

  // Track outstanding operations and the registered idle flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_r <= 4'd0;
      idle_r     <= 1'b1;
    end else begin
      inflight_r <= inflight_nxt_s;
      idle_r     <= (inflight_nxt_s == 4'd0);
    end
  end

  assign mul_a     = mul_a_r;
  assign mul_b     = mul_b_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_id    = rsp_id_r;
  assign rsp_r     = rsp_r_r;
  assign inflight  = inflight_r;
  assign idle      = idle_r;

`ifdef MUL_ARB_PERF_EN
  logic [15:0] cnt_r [N_REQ];

  // Saturating per-requester transfer counters, cleared while hold is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REQ; i++) begin
        cnt_r[i] <= 16'h0000;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (hold) begin
          cnt_r[i] <= 16'h0000;
        end else if (gnt_s[i] && req_valid[i] && (cnt_r[i] != 16'hFFFF)) begin
          cnt_r[i] <= cnt_r[i] + 16'd1;
        end else begin
          cnt_r[i] <= cnt_r[i];
        end
      end
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_cnt
    assign grant_cnt[g*16 +: 16] = cnt_r[g];
  end
`endif

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter. Three instances (LATENCY 0, 1, 3) share
// one stimulus stream; a transfer log indexed by clock edge predicts grants,
// responses and occupancy for every instance on every cycle.
module tb_mul_arbiter;

  localparam int N    = 4;
  localparam int LOGN = 4096;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             hold;
  logic [N-1:0]     req_valid;
  logic [32*N-1:0]  req_a;
  logic [32*N-1:0]  req_b;

  logic [N-1:0]     ready_s     [3];
  logic [31:0]      mul_a_s     [3];
  logic [31:0]      mul_b_s     [3];
  logic [63:0]      mul_r_s     [3];
  logic [N-1:0]     rsp_valid_s [3];
  logic [1:0]       rsp_id_s    [3];
  logic [63:0]      rsp_r_s     [3];
  logic [3:0]       inflight_s  [3];
  logic             idle_s      [3];
`ifdef MUL_ARB_PERF_EN
  logic [16*N-1:0]  gc_s        [3];
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mul_arbiter #(.N_REQ(N), .LATENCY(0)) u_l0 (
    .clk(clk), .rst_n(rst_n), .hold(hold), .req_valid(req_valid), .req_ready(ready_s[0]),
    .req_a(req_a), .req_b(req_b), .mul_a(mul_a_s[0]), .mul_b(mul_b_s[0]), .mul_r(mul_r_s[0]),
    .rsp_valid(rsp_valid_s[0]), .rsp_id(rsp_id_s[0]), .rsp_r(rsp_r_s[0]),
    .inflight(inflight_s[0]),
`ifdef MUL_ARB_PERF_EN
    .grant_cnt(gc_s[0]),
`endif
    .idle(idle_s[0]));

  mul_arbiter #(.N_REQ(N), .LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .hold(hold), .req_valid(req_valid), .req_ready(ready_s[1]),
    .req_a(req_a), .req_b(req_b), .mul_a(mul_a_s[1]), .mul_b(mul_b_s[1]), .mul_r(mul_r_s[1]),
    .rsp_valid(rsp_valid_s[1]), .rsp_id(rsp_id_s[1]), .rsp_r(rsp_r_s[1]),
    .inflight(inflight_s[1]),
`ifdef MUL_ARB_PERF_EN
    .grant_cnt(gc_s[1]),
`endif
    .idle(idle_s[1]));

  mul_arbiter #(.N_REQ(N), .LATENCY(3)) u_l3 (
    .clk(clk), .rst_n(rst_n), .hold(hold), .req_valid(req_valid), .req_ready(ready_s[2]),
    .req_a(req_a), .req_b(req_b), .mul_a(mul_a_s[2]), .mul_b(mul_b_s[2]), .mul_r(mul_r_s[2]),
    .rsp_valid(rsp_valid_s[2]), .rsp_id(rsp_id_s[2]), .rsp_r(rsp_r_s[2]),
    .inflight(inflight_s[2]),
`ifdef MUL_ARB_PERF_EN
    .grant_cnt(gc_s[2]),
`endif
    .idle(idle_s[2]));

  // Multiplier stand-ins of latency 0, 1 and 3.
  logic [63:0] p1_r;
  logic [63:0] p3_r [3];
  assign mul_r_s[0] = {32'd0, mul_a_s[0]} * {32'd0, mul_b_s[0]};
  always @(posedge clk) begin
    p1_r    <= {32'd0, mul_a_s[1]} * {32'd0, mul_b_s[1]};
    p3_r[0] <= {32'd0, mul_a_s[2]} * {32'd0, mul_b_s[2]};
    p3_r[1] <= p3_r[0];
    p3_r[2] <= p3_r[1];
  end
  assign mul_r_s[1] = p1_r;
  assign mul_r_s[2] = p3_r[2];

  function automatic int lat_of(input int k);
    case (k)
      0:       return 0;
      1:       return 1;
      default: return 3;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: which requester transferred at each edge.
  bit          log_v  [LOGN];
  int          log_id [LOGN];
  logic [31:0] log_a  [LOGN];
  logic [31:0] log_b  [LOGN];
  int          cyc       = 0;
  int          live_from = 0;
  int          m_ptr     = 0;
  logic [31:0] m_a, m_b;
  logic [63:0] last_r  [3];
  int          last_id [3];
  int          n_xfer  = 0;

  initial begin
    int t, cnt, lat, idx, id;
    logic [N-1:0] exp_g, exp_v;
    forever begin
      @(negedge clk);
      if (cyc + 2 >= LOGN) begin
        $display("FAIL log_overflow actual=%0d limit=%0d", cyc, LOGN);
        $fatal(1);
      end
      if (!rst_n) begin
        live_from      = cyc + 1;
        log_v[cyc + 1] = 1'b0;
        m_ptr = 0; m_a = 32'd0; m_b = 32'd0;
        for (int k = 0; k < 3; k++) begin
          last_r[k] = 64'd0; last_id[k] = 0;
          check($sformatf("rst_rsp_valid_L%0d", lat_of(k)), 64'(rsp_valid_s[k]), 64'd0);
          check($sformatf("rst_inflight_L%0d", lat_of(k)), 64'(inflight_s[k]), 64'd0);
          check($sformatf("rst_idle_L%0d", lat_of(k)), 64'(idle_s[k]), 64'd1);
          check($sformatf("rst_mul_a_L%0d", lat_of(k)), 64'(mul_a_s[k]), 64'd0);
          check($sformatf("rst_rsp_r_L%0d", lat_of(k)), rsp_r_s[k], 64'd0);
          check($sformatf("rst_rsp_id_L%0d", lat_of(k)), 64'(rsp_id_s[k]), 64'd0);
        end
      end else begin
        if (cyc >= live_from && log_v[cyc]) begin
          m_ptr = (log_id[cyc] + 1) % N;
          m_a   = log_a[cyc];
          m_b   = log_b[cyc];
        end
        for (int k = 0; k < 3; k++) begin
          lat   = lat_of(k);
          t     = cyc - lat - 1;
          exp_v = 4'b0000;
          if (t >= live_from && log_v[t]) begin
            exp_v      = 4'b0001 << log_id[t];
            last_id[k] = log_id[t];
            last_r[k]  = {32'd0, log_a[t]} * {32'd0, log_b[t]};
          end
          check($sformatf("rsp_valid_L%0d", lat), 64'(rsp_valid_s[k]), 64'(exp_v));
          check($sformatf("rsp_id_L%0d", lat), 64'(rsp_id_s[k]), 64'(last_id[k]));
          check($sformatf("rsp_r_L%0d", lat), rsp_r_s[k], last_r[k]);
          check($sformatf("mul_a_L%0d", lat), 64'(mul_a_s[k]), 64'(m_a));
          check($sformatf("mul_b_L%0d", lat), 64'(mul_b_s[k]), 64'(m_b));
          cnt = 0;
          for (int e = cyc - lat; e <= cyc; e++) begin
            if (e >= live_from && log_v[e]) cnt++;
          end
          check($sformatf("inflight_L%0d", lat), 64'(inflight_s[k]), 64'(cnt));
          check($sformatf("idle_L%0d", lat), 64'(idle_s[k]), 64'(cnt == 0));
          check($sformatf("inflight_bound_L%0d", lat), 64'(inflight_s[k] <= 4'(lat + 1)), 64'd1);
        end
        exp_g = 4'b0000;
        id    = 0;
        if (!hold) begin
          for (int j = 0; j < N; j++) begin
            idx = (m_ptr + j) % N;
            if (req_valid[idx] && exp_g == 4'b0000) begin
              exp_g[idx] = 1'b1;
              id = idx;
            end
          end
        end
        for (int k = 0; k < 3; k++) begin
          check($sformatf("req_ready_L%0d", lat_of(k)), 64'(ready_s[k]), 64'(exp_g));
        end
        log_v[cyc + 1] = (exp_g != 4'b0000);
        log_id[cyc + 1] = id;
        log_a[cyc + 1]  = req_a[32*id +: 32];
        log_b[cyc + 1]  = req_b[32*id +: 32];
        if (exp_g != 4'b0000) n_xfer++;
      end
      cyc++;
    end
  end

  // Directed scenarios with hand-computed expectations, then random traffic.
  initial begin
    logic [3:0] eg;
    int start_x, cycles;
    rst_n = 1'b0; hold = 1'b0; req_valid = 4'b0000;
    req_a = {(32*N){1'b0}}; req_b = {(32*N){1'b0}};
    repeat (3) tick();
    rst_n = 1'b1;

    // Single requester, LATENCY=1 instance: product 0x23456789*0x34567891.
    req_valid = 4'b0001;
    req_a[31:0] = 32'h23456789;
    req_b[31:0] = 32'h34567891;
    @(negedge clk);
    check("t1_grant", 64'(ready_s[1]), 64'h1);
    tick();
    req_valid = 4'b0000;
    @(negedge clk);
    check("t1_inflight_a", 64'(inflight_s[1]), 64'd1);
    tick();
    @(negedge clk);
    check("t1_no_rsp_yet", 64'(rsp_valid_s[1]), 64'd0);
    tick();
    @(negedge clk);
    check("t1_rsp_valid", 64'(rsp_valid_s[1]), 64'h1);
    check("t1_rsp_r", rsp_r_s[1], 64'h073602F5_1EDDDC99);
    check("t1_rsp_id", 64'(rsp_id_s[1]), 64'd0);
    check("t1_idle", 64'(idle_s[1]), 64'd1);
    repeat (5) tick();

    // All four requesters continuously from reset: grants rotate 0,1,2,3,...
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      req_a = {$urandom, $urandom, $urandom, $urandom};
      req_b = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      eg = 4'b0001 << (i % 4);
      check("t2_grant_seq", 64'(ready_s[1]), 64'(eg));
      tick();
    end
    req_valid = 4'b0000;
    repeat (6) tick();

    // Requesters 1 and 3 from reset; requester 0 joins after a grant to 3.
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    req_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      eg = (i % 2 == 0) ? 4'b0010 : 4'b1000;
      check("t3_grant_seq", 64'(ready_s[1]), 64'(eg));
      tick();
    end
    req_valid = 4'b1011;
    @(negedge clk);
    check("t3_grant_to_0", 64'(ready_s[1]), 64'h1);
    tick();
    req_valid = 4'b0000;
    repeat (6) tick();

    // Hold with two operations in flight: both still respond, inflight drains.
    req_valid = 4'b0011;
    tick(); tick();
    hold = 1'b1;
    @(negedge clk);
    check("t4_ready_held", 64'(ready_s[1]), 64'd0);
    check("t4_inflight_2", 64'(inflight_s[1]), 64'd2);
    tick();
    @(negedge clk);
    check("t4_inflight_1", 64'(inflight_s[1]), 64'd1);
    tick();
    @(negedge clk);
    check("t4_inflight_0", 64'(inflight_s[1]), 64'd0);
    check("t4_idle", 64'(idle_s[1]), 64'd1);
    tick();
    hold = 1'b0; req_valid = 4'b0000;
    repeat (6) tick();

    // Asynchronous reset between edges with two operations in flight.
    req_valid = 4'b0011;
    tick(); tick();
    req_valid = 4'b0000;
    check("t5_inflight_before", 64'(inflight_s[1]), 64'd2);
    #1 rst_n = 1'b0;
    #1;
    check("t5_async_inflight", 64'(inflight_s[1]), 64'd0);
    check("t5_async_idle", 64'(idle_s[1]), 64'd1);
    check("t5_async_mul_a", 64'(mul_a_s[1]), 64'd0);
    check("t5_async_inflight_L3", 64'(inflight_s[2]), 64'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t5_no_rsp_L1", 64'(rsp_valid_s[1]), 64'd0);
      check("t5_no_rsp_L3", 64'(rsp_valid_s[2]), 64'd0);
      tick();
    end

    // Random traffic until 100 more transfers, bounded by a cycle budget.
    start_x = n_xfer;
    cycles  = 0;
    while ((n_xfer - start_x) < 100 && cycles < 1000) begin
      req_valid = 4'($urandom);
      hold      = ($urandom_range(0, 7) == 0);
      req_a     = {$urandom, $urandom, $urandom, $urandom};
      req_b     = {$urandom, $urandom, $urandom, $urandom};
      tick();
      cycles++;
    end
    check("random_transfers_done", 64'((n_xfer - start_x) >= 100), 64'd1);
    req_valid = 4'b0000; hold = 1'b0;
    repeat (8) tick();
    @(negedge clk);
    check("final_idle_L0", 64'(idle_s[0]), 64'd1);
    check("final_idle_L3", 64'(idle_s[2]), 64'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

endmodule
